mor1kx_rf_wrport_arbiter_cappuccino: RTL and testbench



---
 rtl/mor1kx_rf_wrport_arbiter_cappuccino_pkg.sv | 15 +
 rtl/mor1kx_rf_clear_seq_cappuccino.sv | 29 ++
 rtl/mor1kx_rf_wrport_arbiter_cappuccino.sv | 142 ++++++++++++++
 tb/tb_mor1kx_rf_wrport_arbiter_cappuccino.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_rf_wrport_arbiter_cappuccino_pkg.sv
// Shared definitions for the cappuccino register-file write-port arbiter:
// the SPR group that maps onto the GPR file and the arbiter FSM encoding.
package mor1kx_rf_wrport_arbiter_cappuccino_pkg;

  localparam logic [6:0] SPR_GPR_GROUP = 7'h2;

  typedef enum logic [2:0] {
    RF_CLEAR = 3'd0,
    RF_IDLE  = 3'd1,
    RF_WPEND = 3'd2,
    RF_RWAIT = 3'd3,
    RF_DONE  = 3'd4
  } rf_arb_state_e;

endpackage

// File: rtl/mor1kx_rf_clear_seq_cappuccino.sv
// Post-reset clear address generator: steps through every RAM word once,
// holding its position on cycles where the writeback steals the port.
module mor1kx_rf_clear_seq_cappuccino #(
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     pause_i,
  output logic [RF_ADDR_WIDTH-1:0] clr_adr_o,
  output logic                     done_o
);

  logic [RF_ADDR_WIDTH-1:0] cnt_q;
  logic [RF_ADDR_WIDTH-1:0] cnt_d;
  logic                     step;

  assign step      = en_i & ~pause_i;
  assign cnt_d     = step ? cnt_q + RF_ADDR_WIDTH'(1) : cnt_q;
  assign clr_adr_o = cnt_q;
  // done marks the cycle that writes the last word, so the owner can leave on this edge
  assign done_o    = step & (&cnt_q);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mor1kx_rf_wrport_arbiter_cappuccino.sv
// Register-file write-port arbiter: writeback > SPR-bus GPR write > post-reset
// clear, plus sequencing of SPR-bus GPR reads through the rfspr RAM copy.
module mor1kx_rf_wrport_arbiter_cappuccino
  import mor1kx_rf_wrport_arbiter_cappuccino_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH    = 32,
  parameter int OPTION_RF_ADDR_WIDTH    = 5,
  parameter int RF_ADDR_WIDTH           = 5,
  parameter int OPTION_RF_CLEAR_ON_INIT = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
  input  logic                            padv_ctrl_i,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_ram_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
  output logic                            spr_rd_en_o,
  output logic [RF_ADDR_WIDTH-1:0]        spr_rd_adr_o,
  output logic                            rf_wren_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
  output logic                            rf_busy_o
);

  localparam logic [9:0] RF_DEPTH = 10'(1 << RF_ADDR_WIDTH);

  rf_arb_state_e                   state_q;
  logic                            ack_q;
  logic [OPTION_OPERAND_WIDTH-1:0] dat_q;
  logic                            busy_q;
  logic [RF_ADDR_WIDTH-1:0]        pend_adr_q;
  logic [OPTION_OPERAND_WIDTH-1:0] pend_dat_q;
  logic                            pend_ok_q;
  logic                            rd_oor_q;

  logic [8:0]               offset;
  logic                     gpr_hit;
  logic                     in_range;
  logic                     idle_wr;
  logic                     idle_rd;
  logic                     pend_wr;
  logic                     clr_en;
  logic                     clr_done;
  logic [RF_ADDR_WIDTH-1:0] clr_adr;

  assign offset   = spr_bus_addr_i[8:0];
  assign gpr_hit  = spr_bus_stb_i & (spr_bus_addr_i[15:9] == SPR_GPR_GROUP);
  assign in_range = {1'b0, offset} < RF_DEPTH;
  assign idle_wr  = (state_q == RF_IDLE) & gpr_hit & spr_bus_we_i;
  assign idle_rd  = (state_q == RF_IDLE) & gpr_hit & ~spr_bus_we_i & ~padv_ctrl_i;

  // rst gates our own write sources so an abandoned access or clear never lands
  assign pend_wr  = ~rst & (state_q == RF_WPEND) & pend_ok_q & ~wb_rf_wb_i;
  assign clr_en   = ~rst & (state_q == RF_CLEAR);

  mor1kx_rf_clear_seq_cappuccino #(
    .RF_ADDR_WIDTH (RF_ADDR_WIDTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .en_i      (clr_en),
    .pause_i   (wb_rf_wb_i),
    .clr_adr_o (clr_adr),
    .done_o    (clr_done)
  );

  assign rf_wren_o = wb_rf_wb_i | pend_wr | clr_en;

  always_comb begin
    rf_wradr_o = clr_adr;
    rf_wrdat_o = '0;
    if (wb_rf_wb_i) begin
      rf_wradr_o = RF_ADDR_WIDTH'(wb_rfd_adr_i);
      rf_wrdat_o = result_i;
    end else if (pend_wr) begin
      rf_wradr_o = pend_adr_q;
      rf_wrdat_o = pend_dat_q;
    end
  end

  // Out-of-range reads still walk RWAIT so their ack timing matches real reads
  assign spr_rd_en_o   = ~rst & idle_rd & in_range;
  assign spr_rd_adr_o  = offset[RF_ADDR_WIDTH-1:0];
  assign spr_gpr_ack_o = ack_q;
  assign spr_gpr_dat_o = dat_q;
  assign rf_busy_o     = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (OPTION_RF_CLEAR_ON_INIT != 0) ? RF_CLEAR : RF_IDLE;
      busy_q  <= (OPTION_RF_CLEAR_ON_INIT != 0);
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        RF_CLEAR: begin
          if (clr_done) begin
            state_q <= RF_IDLE;
            busy_q  <= 1'b0;
          end
        end
        RF_IDLE: begin
          if (idle_wr)      state_q <= RF_WPEND;
          else if (idle_rd) state_q <= RF_RWAIT;
        end
        RF_WPEND: begin
          if (!wb_rf_wb_i) begin
            ack_q   <= 1'b1;
            state_q <= RF_DONE;
          end
        end
        RF_RWAIT: begin
          ack_q   <= 1'b1;
          dat_q   <= rd_oor_q ? '0 : spr_ram_dat_i;
          state_q <= RF_DONE;
        end
        RF_DONE: begin
          if (!spr_bus_stb_i) state_q <= RF_IDLE;
        end
        default: state_q <= RF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (idle_wr) begin
      pend_adr_q <= offset[RF_ADDR_WIDTH-1:0];
      pend_dat_q <= spr_bus_dat_i;
      pend_ok_q  <= in_range;
    end
    if (idle_rd) rd_oor_q <= ~in_range;
  end

endmodule

// File: tb/tb_mor1kx_rf_wrport_arbiter_cappuccino.sv
// Randomized bench for the GPR write-port arbiter with a word-level GPR model
// and a behavioural RAM attached to the write and rfspr read ports.
module tb_mor1kx_rf_wrport_arbiter_cappuccino;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_rf_wb_i, padv_ctrl_i, spr_bus_stb_i, spr_bus_we_i;
  logic [4:0]  wb_rfd_adr_i;
  logic [31:0] result_i, spr_bus_dat_i;
  logic [15:0] spr_bus_addr_i;
  logic        spr_gpr_ack_o, spr_rd_en_o, rf_wren_o, rf_busy_o;
  logic [31:0] spr_gpr_dat_o, rf_wrdat_o;
  logic [4:0]  spr_rd_adr_o, rf_wradr_o;

  logic        n_stb, n_we, n_ack, n_rd_en, n_wren, n_busy;
  logic [15:0] n_addr;
  logic [31:0] n_dat, n_gpr_dat, n_wrdat;
  logic [31:0] n_ram_dat = 32'h0;
  logic [4:0]  n_rd_adr, n_wradr;
  logic        n_wb = 1'b0;
  logic        n_padv = 1'b0;
  logic [4:0]  n_wb_adr = 5'd0;
  logic [31:0] n_result = 32'h0;

  logic [31:0] ram [32];
  logic [31:0] ram_rd_q;
  logic [31:0] exp_gpr [32];
  int          clr_cnt = 0;
  int          spr_req_n = 0, spr_done_n = 0;
  logic [4:0]  spr_req_adr;
  logic [31:0] spr_req_dat;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mor1kx_rf_wrport_arbiter_cappuccino dut (
    .clk(clk), .rst(rst), .wb_rf_wb_i(wb_rf_wb_i), .wb_rfd_adr_i(wb_rfd_adr_i),
    .result_i(result_i), .padv_ctrl_i(padv_ctrl_i), .spr_bus_addr_i(spr_bus_addr_i),
    .spr_bus_stb_i(spr_bus_stb_i), .spr_bus_we_i(spr_bus_we_i), .spr_bus_dat_i(spr_bus_dat_i),
    .spr_ram_dat_i(ram_rd_q), .spr_gpr_ack_o(spr_gpr_ack_o), .spr_gpr_dat_o(spr_gpr_dat_o),
    .spr_rd_en_o(spr_rd_en_o), .spr_rd_adr_o(spr_rd_adr_o), .rf_wren_o(rf_wren_o),
    .rf_wradr_o(rf_wradr_o), .rf_wrdat_o(rf_wrdat_o), .rf_busy_o(rf_busy_o)
  );

  mor1kx_rf_wrport_arbiter_cappuccino #(.OPTION_RF_CLEAR_ON_INIT(0)) dut_nc (
    .clk(clk), .rst(rst), .wb_rf_wb_i(n_wb), .wb_rfd_adr_i(n_wb_adr),
    .result_i(n_result), .padv_ctrl_i(n_padv), .spr_bus_addr_i(n_addr),
    .spr_bus_stb_i(n_stb), .spr_bus_we_i(n_we), .spr_bus_dat_i(n_dat),
    .spr_ram_dat_i(n_ram_dat), .spr_gpr_ack_o(n_ack), .spr_gpr_dat_o(n_gpr_dat),
    .spr_rd_en_o(n_rd_en), .spr_rd_adr_o(n_rd_adr), .rf_wren_o(n_wren),
    .rf_wradr_o(n_wradr), .rf_wrdat_o(n_wrdat), .rf_busy_o(n_busy)
  );

  // Behavioural RAM: rfspr read returns the pre-write contents one cycle later
  always @(posedge clk) begin
    if (rf_wren_o) ram[rf_wradr_o] <= rf_wrdat_o;
    if (spr_rd_en_o) ram_rd_q <= ram[spr_rd_adr_o];
  end

  // GPR model: acked SPR writes land before this edge's writeback; clear zeroes
  // one word per cycle not taken by a writeback until all 32 are done
  always @(posedge clk) begin
    if (spr_req_n != spr_done_n) begin
      exp_gpr[spr_req_adr] = spr_req_dat;
      spr_done_n = spr_req_n;
    end
    if (rst) clr_cnt = 0;
    else if (wb_rf_wb_i) exp_gpr[wb_rfd_adr_i] = result_i;
    else if (clr_cnt < 32) begin
      exp_gpr[clr_cnt[4:0]] = 32'h0;
      clr_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycle();
    spr_bus_stb_i = 1'b0; wb_rf_wb_i = 1'b0; padv_ctrl_i = 1'b0;
    @(negedge clk);
    check_eq("idle_no_ack", spr_gpr_ack_o, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_ram();
    for (int i = 0; i < 32; i++) check_eq($sformatf("ram_r%0d", i), ram[i], exp_gpr[i]);
  endtask

  // One SPR access, strobe held until ack; called and returns at posedge+1
  task automatic spr_xact(input logic wr, input logic [15:0] adr, input logic [31:0] dat,
                          input int wb_force, input int padv_force, input int wb_pct,
                          input int padv_pct, output int ack_cyc, output int rd_cyc,
                          output logic [31:0] rdat);
    logic gpr, inr;
    logic [4:0] ofs;
    int wr_cyc, n_rd, n_wr;
    gpr = (adr[15:9] == 7'h2);
    inr = (adr[8:0] < 9'd32);
    ofs = adr[4:0];
    ack_cyc = -1; rd_cyc = -1; wr_cyc = -1; n_rd = 0; n_wr = 0; rdat = 32'h0;
    for (int c = 0; c < 64 && ack_cyc < 0; c++) begin
      spr_bus_stb_i = 1'b1; spr_bus_we_i = wr; spr_bus_addr_i = adr; spr_bus_dat_i = dat;
      wb_rf_wb_i   = (c < wb_force) || ($urandom_range(0, 99) < wb_pct);
      wb_rfd_adr_i = (c < wb_force) ? ofs : 5'($urandom);
      if (!wr && wb_rfd_adr_i == ofs) wb_rfd_adr_i = ofs ^ 5'd1;
      result_i     = $urandom;
      padv_ctrl_i  = (c < padv_force) || ($urandom_range(0, 99) < padv_pct);
      @(negedge clk);
      if (spr_rd_en_o) begin
        n_rd++; rd_cyc = c;
        check_eq("rd_adr", 32'(spr_rd_adr_o), 32'(ofs));
      end
      if (rf_wren_o && !wb_rf_wb_i) begin
        n_wr++; wr_cyc = c;
        check_eq("spr_wr_adr", 32'(rf_wradr_o), 32'(ofs));
        check_eq("spr_wr_dat", rf_wrdat_o, dat);
      end
      if (spr_gpr_ack_o) begin
        ack_cyc = c;
        rdat = spr_gpr_dat_o;
        if (wr && inr) begin
          spr_req_adr = ofs; spr_req_dat = dat; spr_req_n++;
        end
        if (!wr) check_eq("rd_dat", rdat, inr ? exp_gpr[ofs] : 32'h0);
      end
      @(posedge clk); #1;
    end
    check_eq("ack_seen", 32'(ack_cyc >= 0), 32'(gpr));
    check_eq("rd_issue_n", n_rd, 32'(gpr && !wr && inr));
    check_eq("spr_wr_n", n_wr, 32'(gpr && wr && inr));
    if (gpr && inr && ack_cyc >= 0)
      check_eq("commit_to_ack", wr ? wr_cyc : rd_cyc, ack_cyc - (wr ? 1 : 2));
    for (int h = 0; h < 2; h++) begin
      wb_rf_wb_i = 1'b0; padv_ctrl_i = 1'($urandom);
      @(negedge clk);
      check_eq("no_reack", spr_gpr_ack_o, 1'b0);
      @(posedge clk); #1;
    end
    idle_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_c, rd_c, busy_cycles, steals, cyc, r;
    logic got_ack;
    logic [31:0] rdat;
    logic [15:0] a;
    wb_rf_wb_i = 0; wb_rfd_adr_i = 0; result_i = 0; padv_ctrl_i = 0;
    spr_bus_addr_i = 0; spr_bus_stb_i = 0; spr_bus_we_i = 0; spr_bus_dat_i = 0;
    n_stb = 0; n_we = 0; n_addr = 0; n_dat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", rf_busy_o, 1'b1);
    check_eq("rst_ack", spr_gpr_ack_o, 1'b0);
    check_eq("rst_rd_en", spr_rd_en_o, 1'b0);
    check_eq("rst_dat", spr_gpr_dat_o, 32'h0);
    check_eq("rst_nc_busy", n_busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    fork
      begin : t_noclear
        n_stb = 1'b1; n_we = 1'b1; n_addr = 16'h0401; n_dat = 32'h1111_2222;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check_eq("nc_busy", n_busy, 1'b0);
          check_eq("nc_ack", n_ack, 32'(c == 2));
          if (c == 1) begin
            check_eq("nc_wren", n_wren, 1'b1);
            check_eq("nc_wradr", 32'(n_wradr), 32'd1);
            check_eq("nc_wrdat", n_wrdat, 32'h1111_2222);
          end
          @(posedge clk); #1;
        end
        n_stb = 1'b0;
      end
      begin : t_clear
        cyc = 0; busy_cycles = 0; steals = 0; got_ack = 1'b0;
        spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b1;
        spr_bus_addr_i = 16'h0407; spr_bus_dat_i = 32'h7777_7777;
        while (!got_ack && cyc < 300) begin
          wb_rf_wb_i   = (cyc == 10) || (cyc > 12 && $urandom_range(0, 15) == 0);
          wb_rfd_adr_i = (cyc == 10) ? 5'd3 : 5'($urandom);
          result_i     = (cyc == 10) ? 32'h1234 : $urandom;
          @(negedge clk);
          check_eq("clr_busy", rf_busy_o, 32'(clr_cnt < 32));
          if (rf_busy_o) begin
            busy_cycles++;
            if (wb_rf_wb_i) steals++;
            check_eq("clr_no_ack", spr_gpr_ack_o, 1'b0);
          end
          if (spr_gpr_ack_o) begin
            got_ack = 1'b1;
            spr_req_adr = 5'd7; spr_req_dat = 32'h7777_7777; spr_req_n++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        check_eq("clr_busy_cycles", busy_cycles, 32 + steals);
        check_eq("clr_held_ack", got_ack, 1'b1);
      end
    join
    idle_cycle();
    check_ram();

    spr_xact(1'b1, 16'h0405, 32'hDEAD_BEEF, 3, 0, 0, 0, ack_c, rd_c, rdat);
    check_eq("wr_contend_ack_cyc", ack_c, 4);
    check_eq("wr_contend_r5", ram[5], 32'hDEAD_BEEF);

    spr_xact(1'b1, 16'h0407, 32'hA5A5_A5A5, 0, 0, 0, 0, ack_c, rd_c, rdat);
    spr_xact(1'b0, 16'h0407, 32'h0, 0, 2, 0, 0, ack_c, rd_c, rdat);
    check_eq("rd_issue_cyc", rd_c, 2);
    check_eq("rd_ack_cyc", ack_c, 4);
    check_eq("rd_value", rdat, 32'hA5A5_A5A5);

    spr_xact(1'b1, 16'h0440, 32'hCAFE_F00D, 0, 0, 0, 0, ack_c, rd_c, rdat);
    check_eq("oor_wr_ack_cyc", ack_c, 2);
    spr_xact(1'b0, 16'h0440, 32'h0, 0, 0, 0, 0, ack_c, rd_c, rdat);
    check_eq("oor_rd_ack_cyc", ack_c, 2);
    check_eq("oor_rd_dat", rdat, 32'h0);
    spr_xact(1'b0, 16'h0605, 32'h0, 0, 0, 0, 0, ack_c, rd_c, rdat);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 31);
      if (r == 0)      a = 16'h0600 | 16'($urandom_range(0, 511));
      else if (r < 4)  a = 16'h0400 | 16'($urandom_range(32, 511));
      else             a = 16'h0400 | 16'($urandom_range(0, 31));
      spr_xact(1'($urandom), a, $urandom, 0, 0, 30, 40, ack_c, rd_c, rdat);
    end
    check_ram();

    // Abandon a write stuck in WPEND by reset
    spr_bus_stb_i = 1'b1; spr_bus_we_i = 1'b1; spr_bus_addr_i = 16'h0409;
    spr_bus_dat_i = 32'hBAD0_BAD0; padv_ctrl_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wb_rf_wb_i = (c < 2); wb_rfd_adr_i = 5'd2; result_i = $urandom;
      rst = (c >= 2);
      if (c == 3) spr_bus_stb_i = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_ack", spr_gpr_ack_o, 1'b0);
      check_eq("rst_mid_commit", 32'(rf_wren_o && rf_wrdat_o == 32'hBAD0_BAD0), 32'd0);
      if (c >= 2) check_eq("rst_mid_wren", rf_wren_o, 1'b0);
      @(posedge clk); #1;
    end
    rst = 1'b0; wb_rf_wb_i = 1'b0;
    @(negedge clk);
    check_eq("reclr_busy", rf_busy_o, 1'b1);
    check_eq("reclr_wren", rf_wren_o, 1'b1);
    check_eq("reclr_adr0", 32'(rf_wradr_o), 32'd0);
    check_eq("reclr_dat0", rf_wrdat_o, 32'h0);
    cyc = 0;
    while (rf_busy_o && cyc < 100) begin
      check_eq("reclr_no_ack", spr_gpr_ack_o, 1'b0);
      check_eq("reclr_busy_model", rf_busy_o, 32'(clr_cnt < 32));
      @(posedge clk); #1;
      cyc++;
      @(negedge clk);
    end
    check_eq("reclr_done", rf_busy_o, 1'b0);
    @(posedge clk); #1;
    idle_cycle();
    check_ram();
    check_eq("reclr_r9", ram[9], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
